// File: rtl/lod_expander.sv
// Rebuilds a DATA_W-bit value from a (zero, leading-one position, left-aligned tail) word.
// Two-stage valid/ready pipeline with a saturating output counter and a sticky malformed-input flag.
`timescale 1ns/1ps
module lod_expander #(
  parameter int DATA_W = 8,
  parameter int POS_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_zero,
  input  logic [POS_W-1:0]  in_pos,
  input  logic [DATA_W-2:0] in_tail,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              err_sticky,
  input  logic              err_clr
);

  logic              s1_valid;
  logic              s1_zero;
  logic [POS_W-1:0]  s1_pos;
  logic [DATA_W-2:0] s1_tail;

  logic              s1_en;
  logic              s2_en;
  logic [DATA_W-1:0] decoded;
  logic [DATA_W-1:0] aligned;
  logic [POS_W-1:0]  shift_amt;
  logic              malformed;
  logic              err_set;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en && rst_n;

  // The leading one plus tail forms a left-aligned word; shifting right by
  // (DATA_W-1-pos) puts the one back at bit pos and drops unused tail bits.
  always_comb begin
    aligned   = {1'b1, s1_tail};
    shift_amt = POS_W'(DATA_W - 1) - s1_pos;
    decoded   = s1_zero ? '0 : (aligned >> shift_amt);
    malformed = s1_zero && ((s1_pos != '0) || (s1_tail != '0));
    err_set   = s2_en && s1_valid && malformed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_zero  <= 1'b0;
      s1_pos   <= '0;
      s1_tail  <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_zero <= in_zero;
        s1_pos  <= in_pos;
        s1_tail <= in_tail;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= decoded;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (out_valid && out_ready && (word_cnt != {CNT_W{1'b1}})) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  // A fresh error takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (err_set) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lod_expander.sv
// Directed and streaming checks for lod_expander, plus a narrow-counter instance for saturation.
`timescale 1ns/1ps
module tb_lod_expander;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_zero;
  logic [2:0]  in_pos;
  logic [6:0]  in_tail;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] word_cnt;
  logic        err_sticky;
  logic        err_clr;

  logic        sat_in_valid;
  logic        sat_in_ready;
  logic        sat_out_valid;
  logic        sat_out_ready;
  logic [7:0]  sat_out_data;
  logic [3:0]  sat_word_cnt;
  logic        sat_err_sticky;
  logic        sat_zero;
  logic [2:0]  sat_pos;
  logic [6:0]  sat_tail;
  logic        sat_err_clr;

  int n_checks;
  int n_fail;

  lod_expander #(.DATA_W(8), .POS_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_zero(in_zero), .in_pos(in_pos), .in_tail(in_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .word_cnt(word_cnt), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  lod_expander #(.DATA_W(8), .POS_W(3), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sat_in_valid), .in_ready(sat_in_ready),
    .in_zero(sat_zero), .in_pos(sat_pos), .in_tail(sat_tail),
    .out_valid(sat_out_valid), .out_ready(sat_out_ready), .out_data(sat_out_data),
    .word_cnt(sat_word_cnt), .err_sticky(sat_err_sticky), .err_clr(sat_err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic z, input logic [2:0] p, input logic [6:0] t);
    in_valid = valid;
    in_zero  = z;
    in_pos   = p;
    in_tail  = t;
  endtask

  // Independent model of the upstream leading-one normalizer.
  function automatic void normalize(input logic [7:0] v, output logic z, output logic [2:0] p, output logic [6:0] t);
    z = (v == 8'h00);
    p = 3'd0;
    t = 7'd0;
    for (int i = 0; i < 8; i++) if (v[i]) p = 3'(i);
    for (int j = 0; j < 7; j++) begin
      int src;
      src = int'(p) - 1 - j;
      if (src >= 0) t[6 - j] = v[src];
    end
  endfunction

  logic [2:0] vec_pos  [5];
  logic [6:0] vec_tail [5];
  logic       vec_zero [5];
  logic [7:0] vec_exp  [5];

  initial begin
    logic       z;
    logic [2:0] p;
    logic [6:0] t;
    int         exp_q[$];
    int         idx;
    int         received;
    int         cycles;
    int         accepted;
    logic [7:0] stall_words [2];

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    out_ready = 1'b1;
    err_clr  = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 7'd0);
    sat_in_valid  = 1'b0;
    sat_out_ready = 1'b1;
    sat_zero      = 1'b0;
    sat_pos       = 3'd0;
    sat_tail      = 7'd0;
    sat_err_clr   = 1'b0;

    // Reset state
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_word_cnt", 32'(word_cnt), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_err", 32'(err_sticky), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_in_ready", 32'(in_ready), 32'd1);

    // Directed decode vectors, one per cycle
    vec_pos[0] = 3'd5; vec_tail[0] = 7'b1010000; vec_zero[0] = 1'b0; vec_exp[0] = 8'h34;
    vec_pos[1] = 3'd7; vec_tail[1] = 7'h7F;      vec_zero[1] = 1'b0; vec_exp[1] = 8'hFF;
    vec_pos[2] = 3'd0; vec_tail[2] = 7'h7F;      vec_zero[2] = 1'b0; vec_exp[2] = 8'h01;
    vec_pos[3] = 3'd3; vec_tail[3] = 7'b0110101; vec_zero[3] = 1'b0; vec_exp[3] = 8'h0B;
    vec_pos[4] = 3'd0; vec_tail[4] = 7'h00;      vec_zero[4] = 1'b1; vec_exp[4] = 8'h00;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 5) applyStimulus(1'b1, vec_zero[k], vec_pos[k], vec_tail[k]);
      else applyStimulus(1'b0, 1'b0, 3'd0, 7'd0);
      #1;
      if (k < 2) begin
        checkOutput("dec_latency_empty", 32'(out_valid), 32'd0);
      end else begin
        checkOutput("dec_valid", 32'(out_valid), 32'd1);
        checkOutput($sformatf("dec_data_%0d", k - 2), 32'(out_data), 32'(vec_exp[k - 2]));
      end
    end
    @(negedge clk);
    #1;
    checkOutput("dec_word_cnt", 32'(word_cnt), 32'd5);
    checkOutput("dec_drained", 32'(out_valid), 32'd0);
    checkOutput("dec_no_err", 32'(err_sticky), 32'd0);

    // Malformed word sets the sticky flag
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 3'd2, 7'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'd0, 7'd0);
    @(negedge clk);
    #1;
    checkOutput("err_valid", 32'(out_valid), 32'd1);
    checkOutput("err_data", 32'(out_data), 32'h00);
    checkOutput("err_set", 32'(err_sticky), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("err_sticks", 32'(err_sticky), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    checkOutput("err_clr_alone", 32'(err_sticky), 32'd0);

    // Clear coinciding with a malformed word entering stage 2
    applyStimulus(1'b1, 1'b1, 3'd0, 7'h11);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'd0, 7'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    checkOutput("err_set_wins", 32'(err_sticky), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    // Unused low tail bits are not an error
    applyStimulus(1'b1, 1'b0, 3'd1, 7'h3F);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'd0, 7'd0);
    @(negedge clk);
    #1;
    checkOutput("unused_tail_data", 32'(out_data), 32'h02);
    checkOutput("unused_tail_no_err", 32'(err_sticky), 32'd0);
    @(negedge clk);

    // Full stall: only two words fit
    stall_words[0] = 8'hA5;
    stall_words[1] = 8'h3C;
    accepted = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      normalize(stall_words[accepted < 2 ? accepted : 1], z, p, t);
      applyStimulus(1'b1, z, p, t);
      #1;
      if (in_ready) accepted++;
    end
    checkOutput("stall_accepted", 32'(accepted), 32'd2);
    checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'd0, 7'd0);
    out_ready = 1'b1;
    #1;
    checkOutput("stall_ready_back", 32'(in_ready), 32'd1);
    checkOutput("stall_drain0", 32'(out_data), 32'hA5);
    @(negedge clk);
    #1;
    checkOutput("stall_drain1_valid", 32'(out_valid), 32'd1);
    checkOutput("stall_drain1", 32'(out_data), 32'h3C);
    @(negedge clk);
    #1;
    checkOutput("stall_empty", 32'(out_valid), 32'd0);

    // Stream every 8-bit value with random backpressure
    idx = 0;
    received = 0;
    cycles = 0;
    while (received < 256 && cycles < 4000) begin
      @(negedge clk);
      cycles++;
      if (idx < 256) begin
        normalize(8'(idx), z, p, t);
        applyStimulus(1'b1, z, p, t);
      end else begin
        applyStimulus(1'b0, 1'b0, 3'd0, 7'd0);
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("stream_extra_word", 32'(out_data), 32'hDEAD);
        end else if (out_ready) begin
          checkOutput("stream_data", 32'(out_data), 32'(exp_q.pop_front()));
          received++;
        end else begin
          checkOutput("stream_stall_hold", 32'(out_data), 32'(exp_q[0]));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(idx);
        idx++;
      end
    end
    checkOutput("stream_count", 32'(received), 32'd256);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'd0, 7'd0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("stream_no_dup", 32'(out_valid), 32'd0);

    // Reset with two words in flight
    out_ready = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 3'd2, 7'd0);
    @(negedge clk);
    normalize(8'h5A, z, p, t);
    applyStimulus(1'b1, z, p, t);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'd0, 7'd0);
    #1;
    checkOutput("pre_rst_err", 32'(err_sticky), 32'd1);
    checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_cnt", 32'(word_cnt), 32'd0);
    checkOutput("mid_rst_err", 32'(err_sticky), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    normalize(8'h96, z, p, t);
    applyStimulus(1'b1, z, p, t);
    #1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'd0, 7'd0);
    #1;
    checkOutput("post_rst_no_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
    checkOutput("post_rst_data", 32'(out_data), 32'h96);

    // Saturating counter on the 4-bit instance
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      sat_in_valid = 1'b1;
      #1;
      if (k == 0) checkOutput("sat_in_ready", 32'(sat_in_ready), 32'd1);
      if (k == 10) checkOutput("sat_cnt_mid", 32'(sat_word_cnt), 32'd8);
    end
    @(negedge clk);
    sat_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("sat_cnt_max", 32'(sat_word_cnt), 32'd15);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("sat_cnt_hold", 32'(sat_word_cnt), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
